display_select_ctrl: RTL and testbench
======================================

DISPLAY_SELECT_CTRL -- requirements
Module: display_select_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000; consecutive stable synchronized samples (1 ms at 50 MHz) needed to accept a button level.
REQ-002 Parameter AUTO_PERIOD, default 50000000; clock cycles between auto-advance steps.
REQ-003 Parameter MAX_SELECT, default 7; highest Display_Select value generated (0..MAX_SELECT, must be ≤31).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Clock  in  1  system clock; all state on its rising edge.
REQ-006 Reset_n  in  1  asynchronous active-low reset.
REQ-007 KEY_Next_n  in  1  pushbutton, active-low, asynchronous, bouncing; advance selection.
REQ-008 KEY_Prev_n  in  1  pushbutton, active-low, asynchronous, bouncing; step selection back.
REQ-009 KEY_Show_n  in  1  pushbutton, active-low; hold to show the selected value.
REQ-010 SW_Auto  in  1  slide switch, asynchronous; 1 = auto-cycle mode.
REQ-011 Display_Select  out  5  register selector for the display mux.
REQ-012 Display_Enable  out  1  active-low display enable for the display mux (0 = show, 1 = off).
REQ-013 Select_Changed  out  1  one-cycle pulse on each Display_Select update.

Function
REQ-014 Each of the four inputs SHALL pass a 2-flop synchronizer before any other use.
REQ-015 Each button SHALL have its own debouncer: debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any mismatch-free break restarts the count.
REQ-016 A press event SHALL be a one-cycle pulse on the debounced 1->0 transition; releases generate no event.
REQ-017 Next event: Display_Select +1, MAX_SELECT wraps to 0; Prev event: -1, 0 wraps to MAX_SELECT.
REQ-018 Next and Prev events in the same cycle SHALL leave Display_Select unchanged and assert no Select_Changed.
REQ-019 Latency from the first clock edge sampling a stable low button to the Display_Select update SHALL be exactly DEBOUNCE_CYCLES+3 cycles, Select_Changed high in that same cycle.
REQ-020 FSM states: OFF, SHOW, AUTO, REFRESH.
REQ-021 OFF: Display_Enable=1; debounced Show low -> SHOW; synchronized SW_Auto=1 -> AUTO (SW_Auto has priority).
REQ-022 SHOW: Display_Enable=0; debounced Show high -> OFF; SW_Auto=1 -> AUTO.
REQ-023 AUTO: Display_Enable=0; period counter counts 0..AUTO_PERIOD-1, at terminal count advances Display_Select as a Next event; SW_Auto=0 -> OFF.
REQ-024 In AUTO, a manual Next/Prev event SHALL apply and clear the period counter; a coincident terminal count is ignored that cycle.
REQ-025 Any Display_Select update while in SHOW or AUTO SHALL enter REFRESH: Display_Enable=1 for exactly one cycle, then return to the originating state with Display_Enable=0, so the mux re-latches.
REQ-026 Events arriving during REFRESH SHALL still update Display_Select and extend REFRESH by one cycle.
REQ-027 Updates in OFF SHALL change Display_Select only; Display_Enable stays 1.
REQ-028 All outputs SHALL be registered; no combinational path input->output.

Reset
REQ-029 Reset_n low SHALL immediately force Display_Select=0, Display_Enable=1, Select_Changed=0, FSM=OFF, all counters 0, synchronizers and debounced levels=1 (released), SW_Auto sync=0.
REQ-030 Reset asserted mid-debounce or mid-REFRESH SHALL discard the pending event; after release a button already held low SHALL produce one event only after a full debounce.

Verification (DEBOUNCE_CYCLES=4, AUTO_PERIOD=10, MAX_SELECT=7)
REQ-031 Reset, hold KEY_Next_n low -> Display_Select 0->1 exactly 7 cycles after first sampled low, Select_Changed one cycle, Enable stays 1.
REQ-032 KEY_Next_n bouncing 1-0-1-0 with 2-cycle glitches then stable low -> exactly one increment; seven further presses from 1 -> 0 (wrap); Prev from 0 -> 7.
REQ-033 Hold KEY_Show_n low, then press Next -> Enable 1->0 after debounce, 1 for one cycle at select update, then 0; release Show -> Enable 1.
REQ-034 SW_Auto=1 -> Enable=0, Select 0,1,..7,0 every 10 cycles with one-cycle Enable=1 pulse each step; manual Next mid-period restarts the 10-cycle count.
REQ-035 Next and Prev debounced in same cycle -> no change; Reset_n low during REFRESH -> Select=0, Enable=1 asynchronously.

Source files
------------

// File: rtl/display_select_ctrl.sv
// display_select_ctrl: debounced Next/Prev/Show buttons and auto-cycle mode driving a display register selector
module display_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_PERIOD = 50000000,
  parameter int MAX_SELECT = 7
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       KEY_Next_n,
  input  logic       KEY_Prev_n,
  input  logic       KEY_Show_n,
  input  logic       SW_Auto,
  output logic [4:0] Display_Select,
  output logic       Display_Enable,
  output logic       Select_Changed
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
  typedef enum logic [1:0] {OFF, SHOW, AUTO, REFRESH} state_t;
  logic [2:0] s1, s2, db;
  logic [1:0] db_last, press;
  logic [DW-1:0] cnt [3];
  logic a1, a2;
  state_t state, ret, mode, mode_nx, state_nx;
  logic [AW-1:0] acnt;
  logic tick, inc, dec, upd;
  logic [4:0] sel_nx;
  // two-flop synchronizers; buttons idle released (1), switch idle off (0)
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      s1 <= '1;
      s2 <= '1;
      a1 <= 1'b0;
      a2 <= 1'b0;
    end else begin
      s1 <= {KEY_Show_n, KEY_Prev_n, KEY_Next_n};
      s2 <= s1;
      a1 <= SW_Auto;
      a2 <= a1;
    end
  // per-button debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      db <= '1;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else
      for (int i = 0; i < 3; i++)
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
  // registered one-cycle press pulses on debounced 1->0 of Next and Prev
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      db_last <= '1;
      press <= '0;
    end else begin
      db_last <= db[1:0];
      press <= db_last & ~db[1:0];
    end
  // mode decode, auto tick, next selection and next FSM state
  always_comb begin
    mode = state == REFRESH ? ret : state;
    mode_nx = a2 ? AUTO : mode == AUTO ? OFF : db[2] ? OFF : SHOW;
    tick = mode == AUTO && !(press[0] || press[1]) && acnt == AW'(AUTO_PERIOD - 1);
    inc = (press[0] && !press[1]) || tick;
    dec = press[1] && !press[0];
    upd = inc || dec;
    sel_nx = inc ? (Display_Select == 5'(MAX_SELECT) ? 5'd0 : Display_Select + 5'd1)
           : dec ? (Display_Select == 5'd0 ? 5'(MAX_SELECT) : Display_Select - 5'd1)
           : Display_Select;
    state_nx = upd && mode != OFF && mode_nx != OFF ? REFRESH : mode_nx;
  end
  // FSM, auto period counter and registered outputs
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      state <= OFF;
      ret <= OFF;
      acnt <= '0;
      Display_Select <= '0;
      Display_Enable <= 1'b1;
      Select_Changed <= 1'b0;
    end else begin
      state <= state_nx;
      ret <= mode_nx;
      acnt <= mode != AUTO || press[0] || press[1] || tick ? '0 : acnt + 1'b1;
      Display_Select <= sel_nx;
      Display_Enable <= !(state_nx == SHOW || state_nx == AUTO);
      Select_Changed <= upd;
    end
endmodule

// File: tb/tb_display_select_ctrl.sv
// tb_display_select_ctrl: randomized scoreboard bench for display_select_ctrl
module tb_display_select_ctrl;
  localparam int D = 4, P = 10, M = 7;
  typedef struct {int cyc; int dir;} pend_t;
  typedef struct {int cyc; int sel; bit shown;} exp_t;
  logic Clock = 0, Reset_n = 0, KEY_Next_n = 1, KEY_Prev_n = 1, KEY_Show_n = 1, SW_Auto = 0;
  logic [4:0] Display_Select;
  logic Display_Enable, Select_Changed;
  int checks = 0, errors = 0, cyc = 0, sel = 0, next_tick = -1;
  bit auto_on = 0, show_on = 0, chk_after = 0, exp_after = 0, hit;
  pend_t pend[$];
  exp_t exp_q[$];

  display_select_ctrl #(.DEBOUNCE_CYCLES(D), .AUTO_PERIOD(P), .MAX_SELECT(M)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .KEY_Next_n(KEY_Next_n), .KEY_Prev_n(KEY_Prev_n),
    .KEY_Show_n(KEY_Show_n), .SW_Auto(SW_Auto), .Display_Select(Display_Select),
    .Display_Enable(Display_Enable), .Select_Changed(Select_Changed));

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL timeout actual running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // reference model: events land on known cycles; auto steps every P cycles, restarted by manual events
  always @(posedge Clock) begin : model
    int d;
    bit man;
    cyc = cyc + 1;
    d = 0;
    man = 0;
    while (pend.size() > 0 && pend[0].cyc == cyc) begin
      d += pend[0].dir;
      man = 1;
      void'(pend.pop_front());
    end
    if (man && auto_on) next_tick = cyc + P;
    else if (auto_on && cyc == next_tick) begin
      d = 1;
      next_tick = cyc + P;
    end
    if (d != 0) begin
      sel = (sel + d + M + 1) % (M + 1);
      exp_q.push_back('{cyc, sel, show_on || auto_on});
    end
  end

  // monitor: pops the scoreboard whenever the DUT announces an update
  always @(negedge Clock) begin : monitor
    exp_t e;
    if (!Reset_n) chk_after = 0;
    else begin
      if (chk_after && !Select_Changed) check("enable_after_update", Display_Enable, exp_after);
      chk_after = 0;
      if (Select_Changed) begin
        if (exp_q.size() == 0) check("unexpected_update", Display_Select, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("select", Display_Select, e.sel);
          check("update_cycle", cyc, e.cyc);
          check("enable_at_update", Display_Enable, 1);
          chk_after = 1;
          exp_after = !e.shown;
        end
      end
    end
  end

  task automatic drive(input int dir, input logic v);
    if (dir >= 0) KEY_Next_n = v;
    if (dir <= 0) KEY_Prev_n = v;
  endtask

  // dir 1 = Next, -1 = Prev, 0 = both together; bounce = number of 2-cycle glitches first
  task automatic press(input int dir, input int bounce);
    for (int b = 0; b < bounce; b++) begin
      drive(dir, 0);
      repeat (2) @(negedge Clock);
      drive(dir, 1);
      repeat (2) @(negedge Clock);
    end
    drive(dir, 0);
    if (dir >= 0) pend.push_back('{cyc + 1 + D + 3, 1});
    if (dir <= 0) pend.push_back('{cyc + 1 + D + 3, -1});
    repeat ($urandom_range(12, 7)) @(negedge Clock);
    drive(dir, 1);
    repeat ($urandom_range(12, 8)) @(negedge Clock);
  endtask

  task automatic wait_update();
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge Clock);
      hit = Select_Changed;
    end
    check("update_seen", hit, 1);
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    check("reset_select", Display_Select, 0);
    check("reset_enable", Display_Enable, 1);
    check("reset_changed", Select_Changed, 0);
    Reset_n = 1;
    @(negedge Clock);
    press(1, 0);
    press(1, 2);
    for (int i = 0; i < 6; i++) press(1, 0);
    check("wrap_to_zero", Display_Select, 0);
    press(-1, 0);
    check("prev_wrap", Display_Select, M);
    press(0, 0);
    check("both_no_change", Display_Select, M);
    for (int i = 0; i < 16; i++) press($urandom_range(1, 0) ? 1 : -1, $urandom_range(2, 0));
    KEY_Show_n = 0;
    repeat (12) @(negedge Clock);
    check("show_enable", Display_Enable, 0);
    show_on = 1;
    press(1, 0);
    press(-1, 1);
    KEY_Show_n = 1;
    show_on = 0;
    repeat (12) @(negedge Clock);
    check("show_release_enable", Display_Enable, 1);
    SW_Auto = 1;
    auto_on = 1;
    next_tick = cyc + 1 + 12;
    repeat (6) @(negedge Clock);
    check("auto_enable", Display_Enable, 0);
    repeat (100) @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(9, 1)) @(negedge Clock);
      press($urandom_range(1, 0) ? 1 : -1, 0);
    end
    wait_update();
    SW_Auto = 0;
    auto_on = 0;
    next_tick = -1;
    repeat (8) @(negedge Clock);
    check("auto_off_enable", Display_Enable, 1);
    KEY_Next_n = 0;
    repeat (3) @(negedge Clock);
    Reset_n = 0;
    repeat (2) @(negedge Clock);
    sel = 0;
    pend.delete();
    exp_q.delete();
    check("reset_mid_debounce", Display_Select, 0);
    Reset_n = 1;
    pend.push_back('{cyc + 1 + D + 3, 1});
    repeat (10) @(negedge Clock);
    KEY_Next_n = 1;
    repeat (10) @(negedge Clock);
    check("held_through_reset", Display_Select, 1);
    KEY_Show_n = 0;
    repeat (12) @(negedge Clock);
    show_on = 1;
    KEY_Next_n = 0;
    pend.push_back('{cyc + 1 + D + 3, 1});
    wait_update();
    #2 Reset_n = 0;
    #1;
    check("refresh_reset_select", Display_Select, 0);
    check("refresh_reset_enable", Display_Enable, 1);
    check("refresh_reset_changed", Select_Changed, 0);
    KEY_Next_n = 1;
    KEY_Show_n = 1;
    @(negedge Clock);
    sel = 0;
    show_on = 0;
    pend.delete();
    exp_q.delete();
    @(negedge Clock);
    Reset_n = 1;
    repeat (20) @(negedge Clock);
    check("idle_select", Display_Select, 0);
    check("scoreboard_empty", exp_q.size() + pend.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
